// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-port arbiter for the unified instruction/data memory of the
//            multi-cycle CPU. Port 0 is the CPU datapath and port 1 is the
//            DMA/loader engine. One access is in flight at a time. The
//            arbitration policy is round-robin, or CPU priority with a
//            starvation limit for port 1.
// Ports    : clk_i, reset_i         - clock, synchronous active-high reset
//            reqN_i/weN_i/addrN_i/wdataN_i - request and attributes per port
//            gntN_o                 - request issued to memory this cycle
//            rvalidN_o              - rdata_o is valid for port N
//            rdata_o                - read data, combinational copy of mem_rdata_i
//            mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o - memory command
//            mem_rdata_i            - synchronous-read memory output
//            busy_o                 - an access is in progress
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CPU_PRIO   = 0,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              gnt1_o,
    output logic              rvalid0_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                win_q, win_d;           // 0 = port 0, 1 = port 1
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                last_gnt_q, last_gnt_d;
    logic [3:0]          starve_q, starve_d;

    logic                w_arb_win;
    logic                w_any_req;

    assign w_any_req = req0_i | req1_i;

    // Winner selection, evaluated every cycle but only used in S_IDLE.
    always_comb begin
        w_arb_win = 1'b0;
        if (req1_i && !req0_i) begin
            w_arb_win = 1'b1;
        end else if (req1_i && req0_i) begin
            if (CPU_PRIO == 0) begin
                w_arb_win = ~last_gnt_q;
            end else begin
                // Port 1 is forced once it has lost STARVE_MAX times in a row.
                w_arb_win = (starve_q == C_STARVE_MAX);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            last_gnt_q <= 1'b1;   // port 0 wins the first tie
            starve_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            last_gnt_q <= last_gnt_d;
            starve_q   <= starve_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        last_gnt_d = last_gnt_q;
        starve_d   = starve_q;

        case (state_q)
            S_IDLE: begin
                if (w_any_req) begin
                    state_d    = S_ISSUE;
                    win_d      = w_arb_win;
                    last_gnt_d = w_arb_win;
                    we_d       = w_arb_win ? we1_i    : we0_i;
                    addr_d     = w_arb_win ? addr1_i  : addr0_i;
                    wdata_d    = w_arb_win ? wdata1_i : wdata0_i;
                    if (req1_i && !w_arb_win) begin
                        if (starve_q >= C_STARVE_MAX) begin
                            starve_d = C_STARVE_MAX;
                        end else begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        starve_d = 4'd0;
                    end
                end
            end
            S_ISSUE: begin
                state_d = we_q ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // The command attributes are held in registers so mem_addr/mem_wdata
    // keep their last value between accesses.
    assign mem_en_o    = (state_q == S_ISSUE);
    assign mem_we_o    = (state_q == S_ISSUE) & we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;

    assign gnt0_o      = (state_q == S_ISSUE) & ~win_q;
    assign gnt1_o      = (state_q == S_ISSUE) &  win_q;
    assign rvalid0_o   = (state_q == S_RESP)  & ~win_q;
    assign rvalid1_o   = (state_q == S_RESP)  &  win_q;
    assign rdata_o     = mem_rdata_i;
    assign busy_o      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed bench for mem_arbiter. Two instances share one set of
//            requester inputs: u_rr (round-robin) and u_pr (CPU priority,
//            starvation limit 3). Each instance has its own small
//            synchronous-read memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [31:0] addr0, wdata0, addr1, wdata1;

    logic        g0_rr, g1_rr, v0_rr, v1_rr, en_rr, we_rr, busy_rr;
    logic [31:0] rd_rr, ma_rr, mw_rr;
    logic [31:0] mrd_rr = 32'h0;
    logic        g0_pr, g1_pr, v0_pr, v1_pr, en_pr, we_pr, busy_pr;
    logic [31:0] rd_pr, ma_pr, mw_pr;
    logic [31:0] mrd_pr = 32'h0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CPU_PRIO(0), .STARVE_MAX(3)) u_rr (
        .clk_i(clk), .reset_i(reset),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
        .gnt0_o(g0_rr), .gnt1_o(g1_rr), .rvalid0_o(v0_rr), .rvalid1_o(v1_rr),
        .rdata_o(rd_rr), .mem_en_o(en_rr), .mem_we_o(we_rr),
        .mem_addr_o(ma_rr), .mem_wdata_o(mw_rr), .mem_rdata_i(mrd_rr),
        .busy_o(busy_rr)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .CPU_PRIO(1), .STARVE_MAX(3)) u_pr (
        .clk_i(clk), .reset_i(reset),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
        .gnt0_o(g0_pr), .gnt1_o(g1_pr), .rvalid0_o(v0_pr), .rvalid1_o(v1_pr),
        .rdata_o(rd_pr), .mem_en_o(en_pr), .mem_we_o(we_pr),
        .mem_addr_o(ma_pr), .mem_wdata_o(mw_pr), .mem_rdata_i(mrd_pr),
        .busy_o(busy_pr)
    );

    // Memory model: address 0x10 holds 0xDEADBEEF, every other word reads ~addr.
    always @(posedge clk) begin
        if (en_rr && !we_rr) mrd_rr <= (ma_rr == 32'h10) ? 32'hDEADBEEF : ~ma_rr;
        if (en_pr && !we_pr) mrd_pr <= (ma_pr == 32'h10) ? 32'hDEADBEEF : ~ma_pr;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_rr, exp_pr;
        int         n;

        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = 32'h0; wdata0 = 32'h0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 32'h0; wdata1 = 32'h0;
        tick();
        tick();

        // ---- reset state ----
        check("rst_gnt",    {g1_rr, g0_rr, g1_pr, g0_pr}, 32'h0);
        check("rst_rvalid", {v1_rr, v0_rr, v1_pr, v0_pr}, 32'h0);
        check("rst_mem",    {en_rr, we_rr, busy_rr, en_pr, we_pr, busy_pr}, 32'h0);
        check("rst_addr",   ma_rr, 32'h0);
        check("rst_wdata",  mw_rr, 32'h0);
        reset = 1'b0;

        // ---- single read from port 0 ----
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        tick();
        check("rd_gnt0",   g0_rr, 32'h1);
        check("rd_gnt1",   g1_rr, 32'h0);
        check("rd_memen",  en_rr, 32'h1);
        check("rd_memwe",  we_rr, 32'h0);
        check("rd_addr",   ma_rr, 32'h10);
        check("rd_rv0_early", v0_rr, 32'h0);
        req0 = 1'b0;
        tick();
        check("rd_rvalid0", v0_rr, 32'h1);
        check("rd_rvalid1", v1_rr, 32'h0);
        check("rd_rdata",   rd_rr, 32'hDEADBEEF);
        check("rd_memen_resp", en_rr, 32'h0);
        check("rd_busy_resp", busy_rr, 32'h1);
        tick();
        check("rd_busy_done", busy_rr, 32'h0);
        check("rd_rvalid_done", v0_rr, 32'h0);

        // ---- both ports writing continuously: RR order 0,1,0,1; prio 0,0,0,1 ----
        do_reset();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h100; wdata0 = 32'h11111111;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h200; wdata1 = 32'h22222222;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t % 2 == 1) begin
                n = (t - 1) / 2;
                exp_rr = (n % 2 == 1) ? 2'b10 : 2'b01;
                exp_pr = (n % 4 == 3) ? 2'b10 : 2'b01;
            end else begin
                exp_rr = 2'b00;
                exp_pr = 2'b00;
            end
            check($sformatf("rr_gnt_t%0d", t), {g1_rr, g0_rr}, {30'h0, exp_rr});
            check($sformatf("pr_gnt_t%0d", t), {g1_pr, g0_pr}, {30'h0, exp_pr});
            if (exp_pr != 2'b00) begin
                check($sformatf("pr_addr_t%0d", t), ma_pr, exp_pr[1] ? 32'h200 : 32'h100);
                check($sformatf("pr_we_t%0d", t), we_pr, 32'h1);
            end
        end

        // ---- port 1 write ----
        do_reset();
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h200; wdata1 = 32'hA5A5A5A5;
        tick();
        check("wr1_gnt1",  g1_rr, 32'h1);
        check("wr1_memwe", we_rr, 32'h1);
        check("wr1_addr",  ma_rr, 32'h200);
        check("wr1_wdata", mw_rr, 32'hA5A5A5A5);
        req1 = 1'b0;
        tick();
        check("wr1_idle",   busy_rr, 32'h0);
        check("wr1_memwe_off", we_rr, 32'h0);
        check("wr1_wdata_hold", mw_rr, 32'hA5A5A5A5);
        check("wr1_no_rv",  {v1_rr, v0_rr}, 32'h0);
        tick();
        check("wr1_no_rv2", {v1_rr, v0_rr}, 32'h0);

        // ---- port 1 arrives during port 0 ISSUE of a read ----
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        tick();
        check("late_gnt0", g0_rr, 32'h1);
        req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h20;
        tick();
        check("late_rv0",  v0_rr, 32'h1);
        check("late_gnt1_resp", g1_rr, 32'h0);
        tick();
        check("late_gnt1_idle", g1_rr, 32'h0);
        check("late_busy_idle", busy_rr, 32'h0);
        tick();
        check("late_gnt1", g1_rr, 32'h1);
        check("late_addr", ma_rr, 32'h20);
        req1 = 1'b0;
        tick();
        check("late_rv1",    {v1_rr, v0_rr}, 32'h2);
        check("late_rdata1", rd_rr, 32'hFFFFFFDF);

        // ---- reset during S_RESP aborts the access ----
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; wdata0 = 32'h1234;
        tick();
        req0 = 1'b0;
        tick();
        check("abort_rv0_before", v0_rr, 32'h1);
        reset = 1'b1;
        tick();
        check("abort_rvalid", {v1_rr, v0_rr, v1_pr, v0_pr}, 32'h0);
        check("abort_gnt",    {g1_rr, g0_rr, g1_pr, g0_pr}, 32'h0);
        check("abort_mem",    {en_rr, we_rr, busy_rr}, 32'h0);
        check("abort_addr",   ma_rr, 32'h0);
        check("abort_wdata",  mw_rr, 32'h0);
        reset = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        tick();
        check("abort_first_rr", {g1_rr, g0_rr}, 32'h1);
        check("abort_first_pr", {g1_pr, g0_pr}, 32'h1);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter for the single unified instruction/data memory of the multi-cycle CPU. It shares the memory between the CPU datapath (port 0: fetch and lw/sw via IorD) and a DMA/loader engine (port 1). It serializes accesses through a small FSM, returns read data to the winning port, and enforces round-robin or CPU-priority arbitration with bounded starvation. The CPU controller treats a missing `gnt0`/`rvalid0` as a stall.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `CPU_PRIO`, 0, 0 = round-robin; 1 = port 0 wins ties, subject to starvation limit
- `STARVE_MAX`, 3, consecutive lost arbitrations after which port 1 is forced (used only when `CPU_PRIO`=1; legal range 1..15)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `req0`, `req1`  in  1  access request; held with its attributes until the matching `gnt` is seen
- `we0`, `we1`  in  1  1 = write, 0 = read
- `addr0`, `addr1`  in  ADDR_W  byte address
- `wdata0`, `wdata1`  in  DATA_W  write data
- `gnt0`, `gnt1`  out  1  one-cycle pulse; the request was issued to memory this cycle
- `rvalid0`, `rvalid1`  out  1  one-cycle pulse; `rdata` is valid for this port
- `rdata`  out  DATA_W  shared read-return bus; a combinational copy of `mem_rdata`
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DATA_W  memory write data
- `mem_rdata`  in  DATA_W  synchronous-read memory output, valid the cycle after `mem_en`/`!mem_we`
- `busy`  out  1  FSM not in IDLE

## Operation
- State `S_IDLE`: sample `req0`/`req1`. If neither is asserted, stay. Otherwise pick the winner, register its `we`/`addr`/`wdata` into the `mem_*` outputs, and go to `S_ISSUE`.
- State `S_ISSUE` (1 cycle): `mem_en`=1, `gnt<winner>`=1, and `mem_*` hold the registered attributes. Requests are ignored here. Next state is `S_RESP` for a read and `S_IDLE` for a write.
- State `S_RESP` (1 cycle): `rvalid<winner>`=1, `rdata`=`mem_rdata`, `mem_en`=0. Next state is `S_IDLE`.
- Arbitration with one request pending: that port wins.
- Arbitration with both requests pending, `CPU_PRIO`=0: the winner is the port not in `last_gnt`.
- Arbitration with both requests pending, `CPU_PRIO`=1: port 0 wins unless `starve_cnt` == `STARVE_MAX`, in which case port 1 wins.
- `last_gnt` updates to the winner in every IDLE→ISSUE transition.
- `starve_cnt` (4-bit, saturating at `STARVE_MAX`) increments when port 1 requests but loses. It clears when port 1 wins or when `req1`=0 at an arbitration.
- Outside `S_ISSUE`, `mem_we`=0 and `mem_en`=0. `mem_addr`/`mem_wdata` hold their last value.
- Requester rule: after seeing `gnt`, a requester drops `req` or presents a new request. Changes to a request before its grant are illegal and are not checked.

## Timing
- Request asserted before edge k and sampled in IDLE → `gnt` and `mem_en` during cycle k+1 → `rvalid` during cycle k+2 for a read.
- Minimum access period: 2 cycles for a write, 3 cycles for a read.
- A request arriving during `S_ISSUE`/`S_RESP` waits and is arbitrated in the next `S_IDLE`.
- Reset values (next edge with `reset`=1, from any state):
  - state `S_IDLE`
  - `gnt0`=`gnt1`=`rvalid0`=`rvalid1`=0
  - `mem_en`=`mem_we`=0
  - `mem_addr`=0, `mem_wdata`=0
  - `busy`=0
  - `last_gnt`=1, so port 0 wins the first tie
  - `starve_cnt`=0
- Reset during `S_ISSUE` or `S_RESP` aborts the access. No `gnt`/`rvalid` is produced afterwards, and requesters must reissue.
- `gnt0`&`gnt1` and `rvalid0`&`rvalid1` are never both asserted.

## Test plan
- Reset, then `req0`, `we0`=0, `addr0`=0x10; memory returns 0xDEADBEEF → cycle 1: `gnt0`=1, `mem_en`=1, `mem_we`=0, `mem_addr`=0x10; cycle 2: `rvalid0`=1, `rdata`=0xDEADBEEF; cycle 3: `busy`=0.
- `CPU_PRIO`=0, `req0` and `req1` held continuously with writes → grant order 0,1,0,1 with `gnt` pulses spaced 2 cycles apart.
- `CPU_PRIO`=1, `STARVE_MAX`=3, both requesting continuously with writes → grant order 0,0,0,1,0,0,0,1.
- `req1` write of 0xA5A5A5A5 to 0x200 → `mem_we`=1, `mem_wdata`=0xA5A5A5A5; no `rvalid1`; FSM back in IDLE the next cycle.
- `req1` raised during port 0's `S_ISSUE` cycle of a read → port 1 is not granted until after `rvalid0`; `gnt1` appears 2 cycles after `rvalid0`.
- `reset` asserted in `S_RESP` → the next cycle shows all outputs at their reset values with `rvalid0`=0; then `req0`=`req1`=1 yields `gnt0` first.
